// File: rtl/riscv_pkg.sv
// riscv_pkg: writeback select and load funct3 encodings shared by the writeback slice
package riscv_pkg;
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_RSVD = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [31:0] alu_result;
        logic [31:0] pc;
        logic [31:0] load_word;
        logic [2:0]  funct3;
    } wb_reg_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a loaded word and sign/zero-extends it
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        legal
);
    logic [7:0]  b;
    logic [15:0] h;

    // lane select then extension; unknown funct3 yields zero and legal=0
    always_comb begin
        b = offset[1] ? (offset[0] ? word[31:24] : word[23:16]) : (offset[0] ? word[15:8] : word[7:0]);
        h = offset[1] ? word[31:16] : word[15:0];
        legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
               funct3 == F3_LBU ? {24'd0, b} :
               funct3 == F3_LH  ? {{16{h[15]}}, h} :
               funct3 == F3_LHU ? {16'd0, h} :
               funct3 == F3_LW  ? word : '0;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, result select and retire counter; WB_BYPASS_EN adds WB->decode forwarding
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_reg_wen,
    input  logic [4:0]          mem_rd,
    input  logic [1:0]          mem_wb_sel,
    input  logic [31:0]         mem_alu_result,
    input  logic [31:0]         mem_pc,
    input  logic [31:0]         mem_load_word,
    input  logic [2:0]          mem_funct3,
    input  logic                stall,
    input  logic                flush,
    output logic [31:0]         addr_rd,
    output logic [31:0]         data_rd,
    output logic                write_enable,
    output logic                wb_valid,
    output logic [RETIRE_W-1:0] retire_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [31:0]         addr_rs1,
    input  logic [31:0]         addr_rs2,
    input  logic [31:0]         rf_data_rs1,
    input  logic [31:0]         rf_data_rs2,
    output logic [31:0]         fwd_data_rs1,
    output logic [31:0]         fwd_data_rs2
`endif
);
    wb_reg_t             wb;
    logic [RETIRE_W-1:0] retire_q;
    logic [31:0]         ld_data;
    logic                ld_legal;

    load_extend u_load_extend (
        .word   (wb.load_word),
        .offset (wb.alu_result[1:0]),
        .funct3 (wb.funct3),
        .data   (ld_data),
        .legal  (ld_legal)
    );

    // WB register: reset clears, flush kills the slot even under stall, stall holds
    always_ff @(posedge clock) begin
        if (reset) begin
            wb <= '0;
        end else if (flush) begin
            wb.valid <= 1'b0;
        end else if (!stall) begin
            wb <= '{valid: mem_valid, reg_wen: mem_reg_wen, rd: mem_rd, wb_sel: mem_wb_sel,
                    alu_result: mem_alu_result, pc: mem_pc, load_word: mem_load_word, funct3: mem_funct3};
        end
    end

    // an instruction retires when it leaves a valid, unstalled WB slot
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_q <= '0;
        end else if (wb.valid && !stall) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    // result mux and write strobe; reserved select and illegal loads never write
    always_comb begin
        data_rd = wb.wb_sel == WB_ALU  ? wb.alu_result :
                  wb.wb_sel == WB_LOAD ? ld_data :
                  wb.wb_sel == WB_PC4  ? wb.pc + 32'd4 : '0;
        write_enable = wb.valid && wb.reg_wen && wb.rd != 5'd0 && wb.wb_sel != WB_RSVD &&
                       (wb.wb_sel != WB_LOAD || ld_legal);
    end

    assign addr_rd      = {27'd0, wb.rd};
    assign wb_valid     = wb.valid;
    assign retire_count = retire_q;

`ifdef WB_BYPASS_EN
    assign fwd_data_rs1 = write_enable && addr_rs1 == addr_rd ? data_rd : rf_data_rs1;
    assign fwd_data_rs2 = write_enable && addr_rs2 == addr_rd ? data_rd : rf_data_rs2;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: random + directed stimulus, queue scoreboard against a behavioural WB model
module tb_writeback_stage;
    localparam int RW = 8;

    logic          clock = 1'b0;
    logic          reset, mem_valid, mem_reg_wen, stall, flush;
    logic [4:0]    mem_rd;
    logic [1:0]    mem_wb_sel;
    logic [31:0]   mem_alu_result, mem_pc, mem_load_word;
    logic [2:0]    mem_funct3;
    logic [31:0]   addr_rd, data_rd;
    logic          write_enable, wb_valid;
    logic [RW-1:0] retire_count;
`ifdef WB_BYPASS_EN
    logic [31:0]   addr_rs1 = '0, addr_rs2 = '0, rf_data_rs1 = '0, rf_data_rs2 = '0;
    logic [31:0]   fwd_data_rs1, fwd_data_rs2;
`endif

    writeback_stage #(.RETIRE_W(RW)) dut (
        .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_reg_wen(mem_reg_wen),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_pc(mem_pc), .mem_load_word(mem_load_word), .mem_funct3(mem_funct3),
        .stall(stall), .flush(flush), .addr_rd(addr_rd), .data_rd(data_rd),
        .write_enable(write_enable), .wb_valid(wb_valid), .retire_count(retire_count)
`ifdef WB_BYPASS_EN
        , .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .rf_data_rs1(rf_data_rs1),
        .rf_data_rs2(rf_data_rs2), .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            known;
        bit            valid;
        bit            we;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [RW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    bit          m_known = 1'b1, m_v = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    int          m_cnt  = 0;

    // load result from the architectural rule: shift the addressed lane down, then extend
    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3, output bit ok);
        logic [31:0] bv, hv;
        bv = (w >> (8 * int'(off))) & 32'hFF;
        hv = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        ok = 1'b1;
        case (f3)
            3'b000:  return bv[7]  ? (bv | 32'hFFFF_FF00) : bv;
            3'b100:  return bv;
            3'b001:  return hv[15] ? (hv | 32'hFFFF_0000) : hv;
            3'b101:  return hv;
            3'b010:  return w;
            default: begin ok = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs at negedge, advance the model, queue the post-edge expectation
    task automatic step(input bit rst, input bit fl, input bit st, input bit v, input bit wen,
                        input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] lw, input logic [2:0] f3,
                        input string nm, input bit lit = 1'b0, input logic [31:0] lit_data = '0,
                        input bit lit_we = 1'b0);
        exp_t        e;
        logic [31:0] d;
        bit          ok;
        @(negedge clock);
        reset = rst; flush = fl; stall = st; mem_valid = v; mem_reg_wen = wen; mem_rd = rd;
        mem_wb_sel = sel; mem_alu_result = alu; mem_pc = pc; mem_load_word = lw; mem_funct3 = f3;
        if (rst) begin
            m_known = 1'b1; m_v = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
        end else begin
            if (m_v && !st) m_cnt = (m_cnt + 1) % (1 << RW);
            if (fl) begin
                m_v = 1'b0; m_we = 1'b0; m_known = 1'b0;
            end else if (!st) begin
                ok = 1'b1;
                case (sel)
                    2'd0:    d = alu;
                    2'd1:    d = ld_model(lw, alu[1:0], f3, ok);
                    2'd2:    d = pc + 32'd4;
                    default: begin d = 32'd0; ok = 1'b0; end
                endcase
                m_known = 1'b1; m_v = v; m_addr = {27'd0, rd}; m_data = d;
                m_we = v && wen && rd != 5'd0 && ok;
            end
        end
        e = '{known: m_known, valid: m_v, we: m_we, addr: m_addr, data: m_data,
              cnt: RW'(m_cnt), name: nm};
        if (lit) begin e.data = lit_data; e.we = lit_we; e.known = 1'b1; end
        q.push_back(e);
    endtask

    task automatic rand_step(input string nm);
        logic [4:0]  rd;
        logic [31:0] pc;
        rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
        step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rd, 2'($urandom),
             $urandom, pc, $urandom, 3'($urandom), nm);
`ifdef WB_BYPASS_EN
        addr_rs1 = {27'd0, 5'($urandom)}; addr_rs2 = {27'd0, 5'($urandom)};
        rf_data_rs1 = $urandom; rf_data_rs2 = $urandom;
`endif
    endtask

    // monitor: one edge per queued expectation, compared 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.name, ".wb_valid"}, 32'(wb_valid), 32'(e.valid));
                chk({e.name, ".write_enable"}, 32'(write_enable), 32'(e.we));
                chk({e.name, ".retire_count"}, 32'(retire_count), 32'(e.cnt));
                if (e.known) begin
                    chk({e.name, ".addr_rd"}, addr_rd, e.addr);
                    chk({e.name, ".data_rd"}, data_rd, e.data);
                end
`ifdef WB_BYPASS_EN
                chk({e.name, ".fwd_rs1"}, fwd_data_rs1,
                    (e.we && addr_rs1 == e.addr) ? e.data : rf_data_rs1);
                chk({e.name, ".fwd_rs2"}, fwd_data_rs2,
                    (e.we && addr_rs2 == e.addr) ? e.data : rf_data_rs2);
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0; mem_valid = 1'b0; mem_reg_wen = 1'b0;
        mem_rd = '0; mem_wb_sel = '0; mem_alu_result = '0; mem_pc = '0; mem_load_word = '0;
        mem_funct3 = '0;
        step(1, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0, 0, 3'd0, "reset");
        step(0, 0, 0, 1, 1, 5'd5, 2'd0, 32'h1234, 32'h100, 0, 3'd0, "alu_wr", 1, 32'h1234, 1);
        step(0, 0, 0, 1, 1, 5'd3, 2'd1, 32'h3, 0, 32'h80FF_7F01, 3'b000, "lb_off3", 1, 32'hFFFF_FF80, 1);
        step(0, 0, 0, 1, 1, 5'd3, 2'd1, 32'h1, 0, 32'h80FF_7F01, 3'b100, "lbu_off1", 1, 32'h0000_007F, 1);
        step(0, 0, 0, 1, 1, 5'd3, 2'd1, 32'h2, 0, 32'h80FF_7F01, 3'b001, "lh_off2", 1, 32'hFFFF_80FF, 1);
        step(0, 0, 0, 1, 1, 5'd3, 2'd1, 32'h0, 0, 32'h80FF_7F01, 3'b101, "lhu_off0", 1, 32'h0000_7F01, 1);
        step(0, 0, 0, 1, 1, 5'd3, 2'd1, 32'h0, 0, 32'h80FF_7F01, 3'b110, "bad_f3", 1, 32'h0, 0);
        step(0, 0, 0, 1, 1, 5'd9, 2'd3, 32'h55, 0, 0, 3'd0, "sel_rsvd", 1, 32'h0, 0);
        step(0, 0, 0, 1, 1, 5'd0, 2'd2, 0, 32'hFFFF_FFFC, 0, 3'd0, "rd0_pc4", 1, 32'h0, 0);
        step(0, 0, 0, 1, 1, 5'd7, 2'd0, 32'hDEAD_BEEF, 0, 0, 3'd0, "wr_r7");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 1, 5'd1, 2'd0, $urandom, 0, 0, 3'd0, "stall_hold");
        step(0, 1, 1, 1, 1, 5'd2, 2'd0, 32'h77, 0, 0, 3'd0, "flush_stall");
        step(0, 0, 0, 1, 1, 5'd4, 2'd2, 0, 32'h40, 0, 3'd0, "pre_rst");
        step(0, 0, 1, 1, 1, 5'd6, 2'd0, 32'h9, 0, 0, 3'd0, "stall_pre_rst");
        step(1, 1, 1, 1, 1, 5'd6, 2'd0, 32'h9, 0, 0, 3'd0, "rst_mid_stall");
        step(0, 0, 0, 0, 1, 5'd6, 2'd0, 32'h9, 0, 0, 3'd0, "idle_after_rst");
        for (int i = 0; i < 300; i++)
            step(0, 0, 0, 1, 1, 5'($urandom_range(1, 31)), 2'd0, $urandom, 0, 0, 3'd0, "wrap_burst");
        for (int i = 0; i < 2000; i++) rand_step("random");
        step(0, 0, 0, 0, 0, 5'd0, 2'd0, 0, 0, 0, 3'd0, "drain");
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
